ped_crossing: RTL and testbench

- Pedestrian-crossing controller that sits directly downstream of the intersection traffic-light controller.
- Consumes its red/yellow/green lamp outputs plus a raw pedestrian push-button.
- Drives the WALK / DON'T-WALK signal heads and a countdown display.
- Grants a crossing only during a full red-only phase; latches a sticky fault on any illegal lamp combination.

---
 rtl/ped_crossing.sv | 253 +++++++++++++++++++++++++
 tb/tb_ped_crossing.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/ped_crossing.sv
// ped_crossing: pedestrian-crossing controller placed downstream of the
// intersection traffic-light controller. It registers the lamp outputs and
// debounces a raw push-button. It grants a WALK / flashing DON'T-WALK
// crossing only on the onset of a clean red-only phase, and latches a sticky
// fault on any illegal lamp combination.
//
// Optional feature: define PED_AUDIO_EN to add the 'chirp' audio-cue output.
module ped_crossing #(
   parameter int WALK_T     = 12,  // cycles of steady WALK
   parameter int FLASH_T    = 6,   // cycles of flashing DON'T-WALK
   parameter int BLINK_P    = 2,   // flash half-period in cycles
   parameter int DEBOUNCE_T = 3,   // synchronized-high cycles to accept a press
   parameter int CW         = 5    // countdown width
) (
   input  logic          clk,
   input  logic          rst,          // asynchronous, active-low
   input  logic          red,
   input  logic          yellow,
   input  logic          green,
   input  logic          ped_btn,      // raw asynchronous push-button
   output logic          walk,
   output logic          dont_walk,
   output logic          req_pending,
   output logic [CW-1:0] countdown,
   output logic          fault
`ifdef PED_AUDIO_EN
   ,
   output logic          chirp
`endif
);

   // ------------------------------------------------------------------
   // Elaboration-time parameter sanity checks
   // ------------------------------------------------------------------
   generate
      if (WALK_T + FLASH_T > (2 ** CW)) begin : g_bad_cw
         $error("ped_crossing: WALK_T+FLASH_T does not fit in CW bits");
      end
      if (WALK_T < 1 || FLASH_T < 1 || BLINK_P < 1 || DEBOUNCE_T < 1) begin : g_bad_time
         $error("ped_crossing: timing parameters must be at least 1");
      end
   endgenerate

   // ------------------------------------------------------------------
   // Local constants
   // ------------------------------------------------------------------
   localparam int DB_W = $clog2(DEBOUNCE_T + 1);
   localparam int PH_W = $clog2(2 * BLINK_P);

   localparam logic [CW-1:0]   CNT_LOAD  = CW'(WALK_T + FLASH_T - 1);
   localparam logic [CW-1:0]   CNT_FLASH = CW'(FLASH_T);
   localparam logic [DB_W-1:0] DB_MAX    = DB_W'(DEBOUNCE_T);
   localparam logic [DB_W-1:0] DB_FIRE   = DB_W'(DEBOUNCE_T - 1);
   localparam logic [PH_W-1:0] PH_WALK_MAX  = PH_W'(2 * BLINK_P - 1);
   localparam logic [PH_W-1:0] PH_FLASH_MAX = PH_W'(BLINK_P - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WALK,
      ST_FLASH,
      ST_FAULT
   } state_e;

   // ------------------------------------------------------------------
   // Registered lamps and button synchronizer
   // ------------------------------------------------------------------
   logic            red_q, yellow_q, green_q;
   logic            red_only_prev_q;
   logic            btn_s1_q, btn_s2_q;
   logic [DB_W-1:0] db_cnt_q, db_cnt_d;

   logic red_only;
   logic start_evt;
   logic lamp_fault;
   logic press_evt;

   assign red_only   = red_q & ~yellow_q & ~green_q;
   assign start_evt  = red_only & ~red_only_prev_q;
   // Green with anything else, or a dark head, is illegal; red+yellow is legal.
   assign lamp_fault = (green_q & (red_q | yellow_q)) | ~(red_q | yellow_q | green_q);
   // One press fires on the cycle the counter steps onto DEBOUNCE_T; the
   // counter then saturates, so holding the button cannot re-fire.
   assign press_evt  = btn_s2_q & (db_cnt_q == DB_FIRE);

   // Lamp register, edge history, button synchronizer and debounce counter.
   // The lamp register resets to red-only (a legal aspect), with red-only
   // history set, so an all-dark reset value never looks like a fault and a
   // red phase already in progress at reset release is not a start event.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         red_q           <= 1'b1;
         yellow_q        <= 1'b0;
         green_q         <= 1'b0;
         red_only_prev_q <= 1'b1;
         btn_s1_q        <= 1'b0;
         btn_s2_q        <= 1'b0;
         db_cnt_q        <= '0;
      end else begin
         // NOTE: non-blocking assignments make every flop sample the
         // pre-edge values, so the synchronizer chain really is two stages.
         red_q           <= red;
         yellow_q        <= yellow;
         green_q         <= green;
         red_only_prev_q <= red_only;
         btn_s1_q        <= ped_btn;
         btn_s2_q        <= btn_s1_q;
         db_cnt_q        <= db_cnt_d;
      end
   end

   // Debounce counter: count synchronized-high cycles, saturate, clear on low.
   always_comb begin
      // NOTE: assigning a default before any branch keeps combinational
      // blocks from inferring latches on paths that forget an assignment.
      db_cnt_d = '0;
      if (btn_s2_q) begin
         db_cnt_d = (db_cnt_q == DB_MAX) ? db_cnt_q : db_cnt_q + DB_W'(1);
      end
   end

   // ------------------------------------------------------------------
   // Crossing FSM
   // ------------------------------------------------------------------
   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;        // crossing countdown
   logic            req_q, req_d;        // latched pedestrian request
   logic [PH_W-1:0] ph_q, ph_d;          // blink / chirp phase
   logic            flash_dw_q, flash_dw_d;

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         req_q      <= 1'b0;
         ph_q       <= '0;
         flash_dw_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         req_q      <= req_d;
         ph_q       <= ph_d;
         flash_dw_q <= flash_dw_d;
      end
   end

   // Next-state logic: a fault beats everything, then abort, then timing.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      req_d      = req_q;
      ph_d       = ph_q;
      flash_dw_d = flash_dw_q;

      case (state_q)
         ST_IDLE: begin
            if (lamp_fault) begin
               state_d = ST_FAULT;
               cnt_d   = '0;
               req_d   = 1'b0;
            end else if (start_evt && req_q) begin
               // Only a request latched before the onset counts; a press
               // landing on the same cycle is absorbed by this crossing.
               state_d = ST_WALK;
               cnt_d   = CNT_LOAD;
               req_d   = 1'b0;
               ph_d    = '0;
            end else if (press_evt) begin
               req_d = 1'b1;
            end
         end

         ST_WALK: begin
            if (lamp_fault) begin
               state_d = ST_FAULT;
               cnt_d   = '0;
               req_d   = 1'b0;
            end else if (!red_only) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_FLASH) begin
               state_d    = ST_FLASH;
               cnt_d      = cnt_q - CW'(1);
               ph_d       = '0;
               flash_dw_d = 1'b1;
            end else begin
               cnt_d = cnt_q - CW'(1);
               ph_d  = (ph_q == PH_WALK_MAX) ? '0 : ph_q + PH_W'(1);
            end
         end

         ST_FLASH: begin
            if (lamp_fault) begin
               state_d = ST_FAULT;
               cnt_d   = '0;
               req_d   = 1'b0;
            end else begin
               // Presses during FLASH queue up for the next red phase.
               if (press_evt) begin
                  req_d = 1'b1;
               end
               if (!red_only) begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end else if (cnt_q == '0) begin
                  state_d = ST_IDLE;
               end else begin
                  cnt_d = cnt_q - CW'(1);
                  if (ph_q == PH_FLASH_MAX) begin
                     ph_d       = '0;
                     flash_dw_d = ~flash_dw_q;
                  end else begin
                     ph_d = ph_q + PH_W'(1);
                  end
               end
            end
         end

         ST_FAULT: begin
            // Sticky until reset; requests are dropped and ignored.
            cnt_d = '0;
            req_d = 1'b0;
         end

         default: begin
            state_d = ST_FAULT;
            cnt_d   = '0;
            req_d   = 1'b0;
         end
      endcase
   end

   // Signal-head outputs decoded from the state register.
   always_comb begin
      dont_walk = 1'b1;
      case (state_q)
         ST_WALK:  dont_walk = 1'b0;
         ST_FLASH: dont_walk = flash_dw_q;
         default:  dont_walk = 1'b1;
      endcase
   end

   assign walk        = (state_q == ST_WALK);
   assign fault       = (state_q == ST_FAULT);
   assign req_pending = req_q;
   assign countdown   = cnt_q;

`ifdef PED_AUDIO_EN
   // Audio cue: one pulse per phase-counter wrap while crossing.
   assign chirp = ((state_q == ST_WALK) || (state_q == ST_FLASH)) && (ph_q == '0);
`endif

endmodule

// File: tb/tb_ped_crossing.sv
// tb_ped_crossing: table-driven directed bench for ped_crossing with default
// parameters, plus hand-written sequences for fault and asynchronous reset.
module tb_ped_crossing;

   localparam int CW = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic          red, yellow, green, ped_btn;
   logic          walk, dont_walk, req_pending, fault;
   logic [CW-1:0] countdown;
`ifdef PED_AUDIO_EN
   logic          chirp;
`endif

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic       r, y, g, b;
      logic       chk;
      logic [8:0] exp;   // {walk, dont_walk, req_pending, countdown, fault}
   } vec_t;

   vec_t vecs[$];

   ped_crossing dut (
      .clk         (clk),
      .rst         (rst),
      .red         (red),
      .yellow      (yellow),
      .green       (green),
      .ped_btn     (ped_btn),
      .walk        (walk),
      .dont_walk   (dont_walk),
      .req_pending (req_pending),
      .countdown   (countdown),
      .fault       (fault)
`ifdef PED_AUDIO_EN
      ,
      .chirp       (chirp)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [8:0] pk(logic w, logic dw, logic rq, logic [4:0] cd, logic f);
      return {w, dw, rq, cd, f};
   endfunction

   function automatic logic [8:0] outs();
      return {walk, dont_walk, req_pending, countdown, fault};
   endfunction

   task automatic add(logic r, logic y, logic g, logic b, logic chk, logic [8:0] e);
      vec_t v;
      v.r = r; v.y = y; v.g = g; v.b = b; v.chk = chk; v.exp = e;
      vecs.push_back(v);
   endtask

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(logic r, logic y, logic g, logic b);
      red = r; yellow = y; green = g; ped_btn = b;
   endtask

   // One clock: inputs set at a falling edge act at the rising edge,
   // outputs are then sampled at the next falling edge.
   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   logic [8:0] rst_vals;
   logic [5:0] fpat;
   int         k;

   initial begin
      rst_vals = pk(1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
      fpat     = 6'b110011;

      // ---- Scenario 1: 8-cycle press during green, then a full red phase
      for (int i = 1; i <= 8; i++) add(0, 0, 1, 1, 1, pk(0, 1, (i >= 5), 0, 0));
      for (int i = 0; i < 2; i++)  add(0, 0, 1, 0, 1, pk(0, 1, 1, 0, 0));
      for (int i = 0; i < 2; i++)  add(0, 1, 0, 0, 1, pk(0, 1, 1, 0, 0));
      add(1, 0, 0, 0, 1, pk(0, 1, 1, 0, 0));                 // onset registered
      for (int i = 0; i < 12; i++) add(1, 0, 0, 0, 1, pk(1, 0, 0, 5'(17 - i), 0));
      for (int i = 0; i < 6; i++)  add(1, 0, 0, 0, 1, pk(0, fpat[5-i], 0, 5'(5 - i), 0));
      for (int i = 0; i < 3; i++)  add(1, 0, 0, 0, 1, pk(0, 1, 0, 0, 0));
      // ---- Scenario 2: 2-cycle glitch is rejected, next red gives no WALK
      for (int i = 0; i < 2; i++)  add(0, 0, 1, 1, 1, pk(0, 1, 0, 0, 0));
      for (int i = 0; i < 5; i++)  add(0, 0, 1, 0, 1, pk(0, 1, 0, 0, 0));
      for (int i = 0; i < 2; i++)  add(0, 1, 0, 0, 1, pk(0, 1, 0, 0, 0));
      for (int i = 0; i < 4; i++)  add(1, 0, 0, 0, 1, pk(0, 1, 0, 0, 0));
      // ---- Scenario 3: press from red cycle 5 waits for the next red phase
      for (int i = 0; i < 5; i++)  add(1, 0, 0, 1, 1, pk(0, 1, (i == 4), 0, 0));
      for (int i = 0; i < 3; i++)  add(1, 0, 0, 0, 1, pk(0, 1, 1, 0, 0));
      for (int i = 0; i < 2; i++)  add(0, 0, 1, 0, 1, pk(0, 1, 1, 0, 0));
      add(0, 1, 0, 0, 1, pk(0, 1, 1, 0, 0));
      add(1, 0, 0, 0, 1, pk(0, 1, 1, 0, 0));
      add(1, 0, 0, 0, 1, pk(1, 0, 0, 17, 0));
      for (int i = 0; i < 4; i++)  add(1, 0, 0, 0, 1, pk(1, 0, 0, 5'(16 - i), 0));
      // ---- Abort: red+yellow from WALK cycle 5
      add(1, 1, 0, 0, 0, pk(0, 0, 0, 0, 0));                 // lamp being registered
      for (int i = 0; i < 2; i++)  add(1, 1, 0, 0, 1, pk(0, 1, 0, 0, 0));

      // ---- Reset state, checked asynchronously before any clock edge
      rst = 1'b0;
      drive(1, 0, 0, 0);
      #2;
      check("reset_t0", outs(), rst_vals);
      @(negedge clk);
      @(negedge clk);
      check("reset_held", outs(), rst_vals);
      rst = 1'b1;

      // ---- Vector table
      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].r, vecs[i].y, vecs[i].g, vecs[i].b);
         cyc();
         if (vecs[i].chk) check($sformatf("vec%0d", i), outs(), vecs[i].exp);
      end

      // ---- Fault: red+green for one cycle
      drive(0, 0, 1, 0); cyc(); cyc();
      drive(1, 0, 1, 0); cyc();
      check("fault_one_edge", fault, 1'b0);
      drive(0, 0, 1, 0); cyc();
      check("fault_two_edges", outs(), pk(0, 1, 0, 0, 1));
      for (int i = 0; i < 6; i++) begin
         drive(0, 0, 1, 1); cyc();
         check($sformatf("fault_hold_press%0d", i), outs(), pk(0, 1, 0, 0, 1));
      end
      drive(0, 1, 0, 0); cyc(); cyc();
      for (int i = 0; i < 4; i++) begin
         drive(1, 0, 0, 0); cyc();
         check($sformatf("fault_hold_red%0d", i), outs(), pk(0, 1, 0, 0, 1));
      end
      #2 rst = 1'b0;
      #1 check("fault_async_clear", outs(), rst_vals);
      @(negedge clk);
      rst = 1'b1;

      // ---- Asynchronous reset in the middle of WALK
      for (int i = 0; i < 5; i++) begin drive(0, 0, 1, 1); cyc(); end
      for (int i = 0; i < 3; i++) begin drive(0, 0, 1, 0); cyc(); end
      check("req_before_walk", req_pending, 1'b1);
      drive(0, 1, 0, 0); cyc(); cyc();
      drive(1, 0, 0, 0);
      k = 0;
      while (!walk && k < 10) begin cyc(); k++; end
      check("walk_reached", walk, 1'b1);
      check("walk_edges_after_onset", k, 2);
      check("walk_first_cd", countdown, 5'd17);
      cyc(); cyc();
      #2 rst = 1'b0;
      #1 check("async_reset_mid_walk", outs(), rst_vals);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(1, 0, 0, 0); cyc();
         check($sformatf("no_walk_after_rst%0d", i), outs(), rst_vals);
      end
      for (int i = 0; i < 3; i++) begin drive(0, 0, 1, 0); cyc(); end
      drive(0, 1, 0, 0); cyc();
      for (int i = 0; i < 5; i++) begin
         drive(1, 0, 0, 0); cyc();
         check($sformatf("no_walk_new_red%0d", i), outs(), rst_vals);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
